wb_byte_bridge: RTL

- Wishbone classic initiator driven by a host byte stream (FT600 or UART receive path). It is the master-side counterpart of the MMIO slot fabric.
- Parses fixed-format read/write command packets from an rx byte stream and issues one single-beat Wishbone cycle per packet.
- Returns a status byte, plus read data when applicable, on a tx byte stream.
- Sits between the host-link byte FIFOs and the MMIO bus, so the host can poke system registers without the CPU.

---
 rtl/ft_mcs_pkg.sv | 31 +++
 rtl/wb_master_single.sv | 68 ++++++
 rtl/wb_byte_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ft_mcs_pkg.sv
// Shared types and codes for the host-link MMIO bridge.
package ft_mcs_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  // Response status bytes
  localparam logic [7:0] ST_ACK = 8'h06;
  localparam logic [7:0] ST_TMO = 8'h15;
  localparam logic [7:0] ST_BAD = 8'h3F;

  // Data bytes following the status byte on a read response
  localparam int unsigned RESP_RD_BYTES = 4;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

  // Single-beat bus request handed from the parser to the cycle engine
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_master_single.sv
// Single-beat Wishbone classic cycle engine with an ACK timeout.
module wb_master_single
  import ft_mcs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  wb_req_t               req_i,
  output logic                  done_c_o,
  output logic                  timeout_c_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic                  cyc_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  tmo_hit_c;

  // ACK takes priority over a coincident timeout
  assign tmo_hit_c   = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign done_c_o    = cyc_q & wb_ack_i;
  assign timeout_c_o = cyc_q & ~wb_ack_i & tmo_hit_c;
  assign rdata_c_o   = wb_dat_i;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;

  // Launch on start, hold until ACK or timeout; counter clears on launch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      tmo_q <= '0;
    end else if (start_i) begin
      cyc_q <= 1'b1;
      we_q  <= req_i.we;
      adr_q <= ADDR_WIDTH'(req_i.adr);
      dat_q <= DATA_WIDTH'(req_i.dat);
      tmo_q <= '0;
    end else if (cyc_q) begin
      if (done_c_o || timeout_c_o) begin
        cyc_q <= 1'b0;
      end
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

endmodule

// File: rtl/wb_byte_bridge.sv
// Byte-stream command parser driving single-beat Wishbone cycles, with byte responses.
module wb_byte_bridge
  import ft_mcs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack,
  output logic                  busy
);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           resp_q, resp_d;
  logic [2:0]            left_q, left_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  busy_q, busy_d;
  logic                  rx_fire_c;
  logic                  start_c;
  logic                  done_c;
  logic                  timeout_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  wb_req_t               req_c;

  assign rx_fire_c = rx_valid & rx_ready_q;
  assign req_c     = '{we: we_q, adr: addr_d, dat: wdata_d};

  assign rx_ready = rx_ready_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

  wb_master_single #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wb_master (
    .CLK        (CLK),
    .RST        (RST),
    .start_i    (start_c),
    .req_i      (req_c),
    .done_c_o   (done_c),
    .timeout_c_o(timeout_c),
    .rdata_c_o  (rdata_c),
    .wb_cyc_o   (wb_cyc),
    .wb_stb_o   (wb_stb),
    .wb_we_o    (wb_we),
    .wb_adr_o   (wb_adr),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack)
  );

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= CMD;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      left_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      left_q     <= left_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Packet parser, bus launch and response sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    left_d     = left_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    start_c    = 1'b0;

    unique case (state_q)
      CMD: begin
        cnt_d = '0;
        if (rx_fire_c) begin
          if (rx_data == CMD_WR) begin
            we_d    = 1'b1;
            state_d = ADDR;
          end else if (rx_data == CMD_RD) begin
            we_d    = 1'b0;
            state_d = ADDR;
          end else begin
            tx_data_d  = ST_BAD;
            tx_valid_d = 1'b1;
            left_d     = '0;
            state_d    = RESP;
          end
        end
      end
      ADDR: begin
        if (rx_fire_c) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = DATA;
            end else begin
              state_d = BUS;
              start_c = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (rx_fire_c) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = BUS;
            start_c = 1'b1;
          end
        end
      end
      BUS: begin
        if (done_c || timeout_c) begin
          tx_data_d  = done_c ? ST_ACK : ST_TMO;
          tx_valid_d = 1'b1;
          resp_d     = (done_c && !we_q) ? 32'(rdata_c) : 32'h0;
          left_d     = we_q ? 3'd0 : 3'(RESP_RD_BYTES);
          state_d    = RESP;
        end
      end
      RESP: begin
        if (tx_ready) begin
          if (left_q == 3'd0) begin
            tx_valid_d = 1'b0;
            state_d    = CMD;
          end else begin
            tx_data_d = resp_q[31:24];
            resp_d    = {resp_q[23:0], 8'h00};
            left_d    = left_q - 3'd1;
          end
        end
      end
      default: state_d = CMD;
    endcase

    rx_ready_d = (state_d == CMD) || (state_d == ADDR) || (state_d == DATA);
    busy_d     = (state_d != CMD);
  end

endmodule
